// File: rtl/operand_buffer.sv
// operand_buffer: circular operand FIFO with block-granular ready flag for the control FSM
module operand_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH_LOG2 = 7,
  parameter int BLOCK_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  wr_valid_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic                  wr_ready_o,
  input  logic                  read_en_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  output logic                  data_rdy_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  underflow_o
);
  localparam int LW = DEPTH_LOG2 + 1;
  localparam int CW = $clog2(BLOCK_LEN + 1);
  localparam logic [LW-1:0] DEPTH = LW'(2 ** DEPTH_LOG2);
  localparam logic [LW-1:0] BL = LW'(BLOCK_LEN);
  localparam logic [CW-1:0] BLC = CW'(BLOCK_LEN);
  typedef enum logic [1:0] {FILL, READY, DRAIN} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic [LW-1:0] level_n;
  logic push, pop, done;
  assign wr_ready_o = level_o < DEPTH;
  assign push = wr_valid_i && wr_ready_o;
  assign pop = read_en_i && level_o != '0;
  assign level_n = level_o + LW'(push) - LW'(pop);
  assign data_rdy_o = state != FILL;
  // The first pop of a block counts as 1; completing a block re-arms from the post-update level.
  always_comb begin
    cnt_inc = state == READY ? CW'(1) : cnt + 1'b1;
    done = cnt_inc == BLC;
    state_n = state;
    cnt_n = cnt;
    if (state == FILL) state_n = level_o >= BL ? READY : FILL;
    else if (pop) begin
      cnt_n = done ? '0 : cnt_inc;
      state_n = !done ? DRAIN : (level_n >= BL ? READY : FILL);
    end
  end
  always_ff @(posedge clk)
    if (!rst && !flush_i && push) mem[wr_ptr] <= wr_data_i;
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level_o <= '0;
      rd_data_o <= '0;
      rd_valid_o <= 1'b0;
      underflow_o <= 1'b0;
      state <= FILL;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_data_o <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      rd_valid_o <= pop;
      level_o <= level_n;
      underflow_o <= underflow_o || (read_en_i && level_o == '0);
      state <= state_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_operand_buffer.sv
// tb_operand_buffer: directed plus random stimulus against a queue-based reference model
module tb_operand_buffer;
  localparam int DW = 16;
  localparam int DL = 7;
  localparam int BL = 64;
  localparam int DEPTH = 1 << DL;
  logic clk = 0, rst = 1, flush_i = 0, wr_valid_i = 0, read_en_i = 0;
  logic [DW-1:0] wr_data_i = '0;
  logic wr_ready_o, rd_valid_o, data_rdy_o, underflow_o;
  logic [DW-1:0] rd_data_o;
  logic [DL:0] level_o;
  int errors = 0, checks = 0;
  logic [DW-1:0] q[$];
  logic m_rdy = 0, m_uf = 0, m_rv = 0;
  logic [DW-1:0] m_rd = '0;
  int m_rem = BL;

  operand_buffer #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .BLOCK_LEN(BL)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .wr_valid_i(wr_valid_i), .wr_data_i(wr_data_i),
    .wr_ready_o(wr_ready_o), .read_en_i(read_en_i), .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
    .data_rdy_o(data_rdy_o), .level_o(level_o), .underflow_o(underflow_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Model: a block is announced one cycle after the queue holds BL words; m_rem counts
  // the words of the announced block still to be popped.
  task automatic tick();
    int pre;
    bit wr_ok, pop;
    logic [DW-1:0] w;
    pre = q.size();
    wr_ok = wr_valid_i && pre < DEPTH;
    pop = read_en_i && pre != 0;
    @(posedge clk);
    #1;
    if (rst || flush_i) begin
      q.delete();
      m_rdy = 0; m_rem = BL; m_uf = 0; m_rv = 0; m_rd = '0;
    end else begin
      w = pre != 0 ? q[0] : '0;
      if (pop) void'(q.pop_front());
      if (wr_ok) q.push_back(wr_data_i);
      m_rv = pop;
      if (pop) m_rd = w;
      if (read_en_i && pre == 0) m_uf = 1;
      if (!m_rdy) begin
        if (pre >= BL) begin m_rdy = 1; m_rem = BL; end
      end else if (pop) begin
        m_rem--;
        if (m_rem == 0) begin m_rdy = q.size() >= BL; m_rem = BL; end
      end
    end
    chk("level", 32'(level_o), 32'(q.size()));
    chk("wr_ready", 32'(wr_ready_o), 32'(q.size() < DEPTH));
    chk("data_rdy", 32'(data_rdy_o), 32'(m_rdy));
    chk("rd_valid", 32'(rd_valid_o), 32'(m_rv));
    chk("rd_data", 32'(rd_data_o), 32'(m_rd));
    chk("underflow", 32'(underflow_o), 32'(m_uf));
  endtask

  task automatic drive(input bit wv, input logic [DW-1:0] wd, input bit re, input int n);
    for (int i = 0; i < n; i++) begin
      wr_valid_i = wv; wr_data_i = wd + DW'(i); read_en_i = re;
      tick();
    end
    wr_valid_i = 0; read_en_i = 0;
  endtask

  initial begin
    rst = 1;
    drive(0, 0, 0, 3);
    rst = 0;
    drive(0, 0, 0, 1);
    drive(1, 16'h0000, 0, BL);
    drive(0, 0, 0, 2);
    drive(0, 0, 1, BL);
    drive(0, 0, 0, 2);
    drive(1, 16'h0000, 0, DEPTH + 1);
    drive(0, 0, 0, 2);
    drive(0, 0, 1, BL);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, BL);
    drive(0, 0, 0, 2);
    drive(1, 16'h0100, 0, 10);
    drive(1, 16'h0200, 1, 5);
    drive(0, 0, 1, 10);
    drive(0, 0, 1, 1);
    drive(0, 0, 0, 2);
    drive(1, 16'h0300, 0, BL);
    drive(0, 0, 0, 2);
    drive(0, 0, 1, 20);
    flush_i = 1;
    drive(1, 16'hdead, 1, 1);
    flush_i = 0;
    drive(0, 0, 0, 1);
    drive(1, 16'h0400, 0, BL);
    drive(0, 0, 0, 3);
    for (int i = 0; i < 4000; i++) begin
      int ph;
      ph = (i / 500) % 4;
      wr_valid_i = $urandom_range(99) < (ph == 0 ? 80 : ph == 1 ? 30 : 60);
      read_en_i = $urandom_range(99) < (ph == 0 ? 30 : ph == 1 ? 80 : 60);
      wr_data_i = DW'($urandom);
      flush_i = $urandom_range(999) < 3;
      rst = $urandom_range(1999) < 1;
      tick();
    end
    rst = 0; flush_i = 0; wr_valid_i = 0; read_en_i = 0;
    drive(0, 0, 0, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
